// File: rtl/bounded_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module  : bounded_sweep_counter
// Brief   : Up/down sweep counter with run-time bounds, step and four sweep modes.
// Revision: 1.0 - initial release
// ============================================================================
module bounded_sweep_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             cfg_load_i,
    input  logic [WIDTH-1:0] cfg_lo_i,
    input  logic [WIDTH-1:0] cfg_hi_i,
    input  logic [WIDTH-1:0] cfg_step_i,
    input  logic [1:0]       cfg_mode_i,
    output logic [WIDTH-1:0] out_o,
    output logic             direction_o,
    output logic             turn_o,
    output logic             done_o,
    output logic             cfg_err_o
);

    typedef enum logic [1:0] {
        MODE_PINGPONG  = 2'b00,
        MODE_WRAP_UP   = 2'b01,
        MODE_WRAP_DOWN = 2'b10,
        MODE_ONE_SHOT  = 2'b11
    } mode_t;

    localparam logic [WIDTH:0] c_one_x = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0] lo_q,   lo_d;
    logic [WIDTH-1:0] hi_q,   hi_d;
    logic [WIDTH-1:0] step_q, step_d;
    mode_t            mode_q, mode_d;
    logic [WIDTH-1:0] out_q,  out_d;
    logic             dir_q,  dir_d;
    logic             turn_q, turn_d;
    logic             done_q, done_d;
    logic             err_q,  err_d;

    // All arithmetic is one bit wider than the count so nothing wraps modulo 2^WIDTH.
    logic [WIDTH:0] w_step_x;
    logic [WIDTH:0] w_out_x;
    logic [WIDTH:0] w_lo_x;
    logic [WIDTH:0] w_hi_x;
    logic [WIDTH:0] w_up_sum;
    logic [WIDTH:0] w_dn_diff;
    logic [WIDTH:0] w_lo_plus;
    logic [WIDTH:0] w_hi_minus;
    logic           w_up_over;
    logic           w_dn_under;
    logic           w_lo_plus_over;
    logic           w_hi_minus_under;
    logic           w_frozen;

    assign w_step_x  = (step_q == '0) ? c_one_x : {1'b0, step_q};
    assign w_out_x   = {1'b0, out_q};
    assign w_lo_x    = {1'b0, lo_q};
    assign w_hi_x    = {1'b0, hi_q};
    assign w_up_sum  = w_out_x + w_step_x;
    assign w_dn_diff = w_out_x - w_step_x;
    assign w_lo_plus = w_lo_x + w_step_x;
    assign w_hi_minus = w_hi_x - w_step_x;

    assign w_up_over        = (w_up_sum > w_hi_x);
    assign w_dn_under       = ($signed(w_dn_diff) < $signed(w_lo_x));
    assign w_lo_plus_over   = (w_lo_plus > w_hi_x);
    assign w_hi_minus_under = ($signed(w_hi_minus) < $signed(w_lo_x));
    assign w_frozen         = err_q | done_q;

    always_comb begin
        lo_d   = lo_q;
        hi_d   = hi_q;
        step_d = step_q;
        mode_d = mode_q;
        out_d  = out_q;
        dir_d  = dir_q;
        turn_d = 1'b0;
        done_d = done_q;
        err_d  = err_q;

        if (cfg_load_i) begin
            lo_d   = cfg_lo_i;
            hi_d   = cfg_hi_i;
            step_d = cfg_step_i;
            mode_d = mode_t'(cfg_mode_i);
            if (cfg_lo_i >= cfg_hi_i) begin
                err_d = 1'b1;
                out_d = cfg_lo_i;
            end else begin
                err_d  = 1'b0;
                done_d = 1'b0;
                if (mode_t'(cfg_mode_i) == MODE_WRAP_DOWN) begin
                    out_d = cfg_hi_i;
                    dir_d = 1'b0;
                end else begin
                    out_d = cfg_lo_i;
                    dir_d = 1'b1;
                end
            end
        end else if (enable_i && !w_frozen) begin
            case (mode_q)
                MODE_PINGPONG: begin
                    if (dir_q) begin
                        if (out_q < hi_q) begin
                            out_d = w_up_over ? hi_q : w_up_sum[WIDTH-1:0];
                        end else begin
                            out_d  = w_hi_minus_under ? lo_q : w_hi_minus[WIDTH-1:0];
                            dir_d  = 1'b0;
                            turn_d = 1'b1;
                        end
                    end else begin
                        if (out_q > lo_q) begin
                            out_d = w_dn_under ? lo_q : w_dn_diff[WIDTH-1:0];
                        end else begin
                            out_d  = w_lo_plus_over ? hi_q : w_lo_plus[WIDTH-1:0];
                            dir_d  = 1'b1;
                            turn_d = 1'b1;
                        end
                    end
                end
                MODE_WRAP_UP: begin
                    dir_d = 1'b1;
                    if (!w_up_over) begin
                        out_d = w_up_sum[WIDTH-1:0];
                    end else begin
                        out_d  = lo_q;
                        turn_d = 1'b1;
                    end
                end
                MODE_WRAP_DOWN: begin
                    dir_d = 1'b0;
                    if (!w_dn_under) begin
                        out_d = w_dn_diff[WIDTH-1:0];
                    end else begin
                        out_d  = hi_q;
                        turn_d = 1'b1;
                    end
                end
                MODE_ONE_SHOT: begin
                    // Clamp at hi and latch done on the same edge; done then freezes the count.
                    dir_d = 1'b1;
                    if (w_up_sum >= w_hi_x) begin
                        out_d  = hi_q;
                        done_d = 1'b1;
                    end else begin
                        out_d = w_up_sum[WIDTH-1:0];
                    end
                end
                default: begin
                    out_d = out_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_q   <= '0;
            hi_q   <= '1;
            step_q <= {{(WIDTH-1){1'b0}}, 1'b1};
            mode_q <= MODE_PINGPONG;
            out_q  <= '0;
            dir_q  <= 1'b1;
            turn_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            lo_q   <= lo_d;
            hi_q   <= hi_d;
            step_q <= step_d;
            mode_q <= mode_d;
            out_q  <= out_d;
            dir_q  <= dir_d;
            turn_q <= turn_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    assign out_o       = out_q;
    assign direction_o = dir_q;
    assign turn_o      = turn_q;
    assign done_o      = done_q;
    assign cfg_err_o   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bounded_sweep_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_bounded_sweep_counter
// Brief   : Directed self-checking bench for bounded_sweep_counter (WIDTH=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_bounded_sweep_counter;

    logic       clk;
    logic       rst;
    logic       enable_i;
    logic       cfg_load_i;
    logic [3:0] cfg_lo_i;
    logic [3:0] cfg_hi_i;
    logic [3:0] cfg_step_i;
    logic [1:0] cfg_mode_i;
    logic [3:0] out_o;
    logic       direction_o;
    logic       turn_o;
    logic       done_o;
    logic       cfg_err_o;

    int n_cmp;
    int n_err;

    bounded_sweep_counter #(.WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .cfg_load_i  (cfg_load_i),
        .cfg_lo_i    (cfg_lo_i),
        .cfg_hi_i    (cfg_hi_i),
        .cfg_step_i  (cfg_step_i),
        .cfg_mode_i  (cfg_mode_i),
        .out_o       (out_o),
        .direction_o (direction_o),
        .turn_o      (turn_o),
        .done_o      (done_o),
        .cfg_err_o   (cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] lo, input logic [3:0] hi,
                           input logic [3:0] st, input logic [1:0] md);
        cfg_lo_i   = lo;
        cfg_hi_i   = hi;
        cfg_step_i = st;
        cfg_mode_i = md;
        cfg_load_i = 1'b1;
        enable_i   = 1'b0;
        tick();
        cfg_load_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable_i = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++; if (out_o !== 4'd0) begin n_err++; $display("FAIL reset_out: got %0d want 0", out_o); end
        n_cmp++; if (direction_o !== 1'b1) begin n_err++; $display("FAIL reset_dir: got %0b want 1", direction_o); end
        n_cmp++; if (turn_o !== 1'b0) begin n_err++; $display("FAIL reset_turn: got %0b want 0", turn_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", done_o); end
        n_cmp++; if (cfg_err_o !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", cfg_err_o); end
    endtask

    task automatic test_default_pingpong();
        logic [3:0] e_out;
        logic       e_dir;
        logic       e_turn;
        enable_i = 1'b1;
        for (int k = 1; k <= 31; k++) begin
            tick();
            e_out  = (k <= 15) ? 4'(k) : (k <= 30) ? 4'(30 - k) : 4'(k - 30);
            e_dir  = (k <= 15 || k == 31);
            e_turn = (k == 16 || k == 31);
            n_cmp++; if (out_o !== e_out) begin n_err++; $display("FAIL pp_default_out[%0d]: got %0d want %0d", k, out_o, e_out); end
            n_cmp++; if (direction_o !== e_dir) begin n_err++; $display("FAIL pp_default_dir[%0d]: got %0b want %0b", k, direction_o, e_dir); end
            n_cmp++; if (turn_o !== e_turn) begin n_err++; $display("FAIL pp_default_turn[%0d]: got %0b want %0b", k, turn_o, e_turn); end
        end
        enable_i = 1'b0;
        tick();
        n_cmp++; if (out_o !== 4'd1) begin n_err++; $display("FAIL hold_out: got %0d want 1", out_o); end
        n_cmp++; if (turn_o !== 1'b0) begin n_err++; $display("FAIL hold_turn: got %0b want 0", turn_o); end
    endtask

    task automatic test_pingpong_bounds();
        logic [3:0] e_out  [5] = '{4'd7, 4'd9, 4'd5, 4'd3, 4'd7};
        logic       e_dir  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic       e_turn [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_load(4'd3, 4'd9, 4'd4, 2'b00);
        n_cmp++; if (out_o !== 4'd3) begin n_err++; $display("FAIL pp_load_out: got %0d want 3", out_o); end
        n_cmp++; if (direction_o !== 1'b1) begin n_err++; $display("FAIL pp_load_dir: got %0b want 1", direction_o); end
        n_cmp++; if (turn_o !== 1'b0) begin n_err++; $display("FAIL pp_load_turn: got %0b want 0", turn_o); end
        enable_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++; if (out_o !== e_out[i]) begin n_err++; $display("FAIL pp_out[%0d]: got %0d want %0d", i, out_o, e_out[i]); end
            n_cmp++; if (direction_o !== e_dir[i]) begin n_err++; $display("FAIL pp_dir[%0d]: got %0b want %0b", i, direction_o, e_dir[i]); end
            n_cmp++; if (turn_o !== e_turn[i]) begin n_err++; $display("FAIL pp_turn[%0d]: got %0b want %0b", i, turn_o, e_turn[i]); end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] up_out  [4] = '{4'd5, 4'd8, 4'd2, 4'd5};
        logic       up_turn [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0] dn_out  [3] = '{4'd7, 4'd4, 4'd10};
        logic       dn_turn [3] = '{1'b0, 1'b0, 1'b1};
        do_load(4'd2, 4'd10, 4'd3, 2'b01);
        n_cmp++; if (out_o !== 4'd2) begin n_err++; $display("FAIL wu_load_out: got %0d want 2", out_o); end
        enable_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++; if (out_o !== up_out[i]) begin n_err++; $display("FAIL wu_out[%0d]: got %0d want %0d", i, out_o, up_out[i]); end
            n_cmp++; if (turn_o !== up_turn[i]) begin n_err++; $display("FAIL wu_turn[%0d]: got %0b want %0b", i, turn_o, up_turn[i]); end
            n_cmp++; if (direction_o !== 1'b1) begin n_err++; $display("FAIL wu_dir[%0d]: got %0b want 1", i, direction_o); end
        end
        do_load(4'd2, 4'd10, 4'd3, 2'b10);
        n_cmp++; if (out_o !== 4'd10) begin n_err++; $display("FAIL wd_load_out: got %0d want 10", out_o); end
        n_cmp++; if (direction_o !== 1'b0) begin n_err++; $display("FAIL wd_load_dir: got %0b want 0", direction_o); end
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_o !== dn_out[i]) begin n_err++; $display("FAIL wd_out[%0d]: got %0d want %0d", i, out_o, dn_out[i]); end
            n_cmp++; if (turn_o !== dn_turn[i]) begin n_err++; $display("FAIL wd_turn[%0d]: got %0b want %0b", i, turn_o, dn_turn[i]); end
            n_cmp++; if (direction_o !== 1'b0) begin n_err++; $display("FAIL wd_dir[%0d]: got %0b want 0", i, direction_o); end
        end
        enable_i = 1'b0;
    endtask

    task automatic test_oneshot();
        logic [3:0] e_out  [6] = '{4'd2, 4'd4, 4'd5, 4'd5, 4'd5, 4'd5};
        logic       e_done [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_load(4'd0, 4'd5, 4'd2, 2'b11);
        n_cmp++; if (out_o !== 4'd0) begin n_err++; $display("FAIL os_load_out: got %0d want 0", out_o); end
        enable_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_cmp++; if (out_o !== e_out[i]) begin n_err++; $display("FAIL os_out[%0d]: got %0d want %0d", i, out_o, e_out[i]); end
            n_cmp++; if (done_o !== e_done[i]) begin n_err++; $display("FAIL os_done[%0d]: got %0b want %0b", i, done_o, e_done[i]); end
            n_cmp++; if (turn_o !== 1'b0) begin n_err++; $display("FAIL os_turn[%0d]: got %0b want 0", i, turn_o); end
        end
        do_load(4'd0, 4'd5, 4'd2, 2'b11);
        n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL os_reload_done: got %0b want 0", done_o); end
        n_cmp++; if (out_o !== 4'd0) begin n_err++; $display("FAIL os_reload_out: got %0d want 0", out_o); end
    endtask

    task automatic test_cfg_err();
        do_load(4'd8, 4'd8, 4'd1, 2'b00);
        n_cmp++; if (cfg_err_o !== 1'b1) begin n_err++; $display("FAIL err_flag: got %0b want 1", cfg_err_o); end
        n_cmp++; if (out_o !== 4'd8) begin n_err++; $display("FAIL err_out: got %0d want 8", out_o); end
        enable_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (out_o !== 4'd8) begin n_err++; $display("FAIL err_frozen_out[%0d]: got %0d want 8", i, out_o); end
            n_cmp++; if (cfg_err_o !== 1'b1) begin n_err++; $display("FAIL err_sticky[%0d]: got %0b want 1", i, cfg_err_o); end
        end
        // Step of zero behaves as a step of one.
        do_load(4'd0, 4'd15, 4'd0, 2'b00);
        n_cmp++; if (cfg_err_o !== 1'b0) begin n_err++; $display("FAIL err_clear: got %0b want 0", cfg_err_o); end
        n_cmp++; if (out_o !== 4'd0) begin n_err++; $display("FAIL err_reload_out: got %0d want 0", out_o); end
        enable_i = 1'b1;
        tick();
        n_cmp++; if (out_o !== 4'd1) begin n_err++; $display("FAIL step0_out1: got %0d want 1", out_o); end
        tick();
        n_cmp++; if (out_o !== 4'd2) begin n_err++; $display("FAIL step0_out2: got %0d want 2", out_o); end
        enable_i = 1'b0;
    endtask

    task automatic test_priority();
        do_load(4'd2, 4'd12, 4'd3, 2'b10);
        enable_i = 1'b1;
        tick();
        n_cmp++; if (out_o !== 4'd9) begin n_err++; $display("FAIL prio_pre_out: got %0d want 9", out_o); end
        rst        = 1'b1;
        cfg_load_i = 1'b1;
        cfg_lo_i   = 4'd5;
        cfg_hi_i   = 4'd9;
        cfg_step_i = 4'd2;
        cfg_mode_i = 2'b01;
        tick();
        rst        = 1'b0;
        cfg_load_i = 1'b0;
        n_cmp++; if (out_o !== 4'd0) begin n_err++; $display("FAIL prio_rst_out: got %0d want 0", out_o); end
        n_cmp++; if (direction_o !== 1'b1) begin n_err++; $display("FAIL prio_rst_dir: got %0b want 1", direction_o); end
        n_cmp++; if (turn_o !== 1'b0) begin n_err++; $display("FAIL prio_rst_turn: got %0b want 0", turn_o); end
        tick();
        n_cmp++; if (out_o !== 4'd1) begin n_err++; $display("FAIL prio_rst_cfg_step: got %0d want 1", out_o); end
        cfg_mode_i = 2'b00;
        cfg_load_i = 1'b1;
        tick();
        cfg_load_i = 1'b0;
        n_cmp++; if (out_o !== 4'd5) begin n_err++; $display("FAIL prio_load_out: got %0d want 5", out_o); end
        n_cmp++; if (turn_o !== 1'b0) begin n_err++; $display("FAIL prio_load_turn: got %0b want 0", turn_o); end
        cfg_lo_i   = 4'd0;
        cfg_hi_i   = 4'd3;
        cfg_step_i = 4'd1;
        cfg_mode_i = 2'b01;
        tick();
        n_cmp++; if (out_o !== 4'd7) begin n_err++; $display("FAIL noload_out1: got %0d want 7", out_o); end
        tick();
        n_cmp++; if (out_o !== 4'd9) begin n_err++; $display("FAIL noload_out2: got %0d want 9", out_o); end
        tick();
        n_cmp++; if (out_o !== 4'd7) begin n_err++; $display("FAIL noload_out3: got %0d want 7", out_o); end
        n_cmp++; if (turn_o !== 1'b1) begin n_err++; $display("FAIL noload_turn: got %0b want 1", turn_o); end
        n_cmp++; if (direction_o !== 1'b0) begin n_err++; $display("FAIL noload_dir: got %0b want 0", direction_o); end
        enable_i = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        enable_i   = 1'b0;
        cfg_load_i = 1'b0;
        cfg_lo_i   = 4'd0;
        cfg_hi_i   = 4'd0;
        cfg_step_i = 4'd0;
        cfg_mode_i = 2'b00;

        test_reset();
        test_default_pingpong();
        test_pingpong_bounds();
        test_wrap();
        test_oneshot();
        test_cfg_err();
        test_priority();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
